// File: rtl/cla_seq_adder_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package cla_seq_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int nibbles(input int width);
        return width / NIB_W;
    endfunction

endpackage

// File: rtl/cla_seq_adder_if.sv
// Operand request / result handshake bundle of the nibble-serial adder.
interface cla_seq_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, overflow, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, overflow, busy
    );
endinterface

// File: rtl/cla_seq_adder_cla_4bit.sv
// Combinational 4-bit carry-lookahead adder slice.
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g_s;
    logic [3:0] p_s;
    logic [4:0] c_s;

    assign g_s = a & b;
    assign p_s = a ^ b;

    assign c_s[0] = cin;
    assign c_s[1] = g_s[0] | (p_s[0] & c_s[0]);
    assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & c_s[0]);
    assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & c_s[0]);
    assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                  | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                  | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & c_s[0]);

    assign sum  = p_s ^ c_s[3:0];
    assign cout = c_s[4];
endmodule

// File: rtl/cla_seq_adder.sv
// WIDTH-bit adder that reuses one cla_4bit slice, one nibble per clock, LSB first,
// behind valid/ready request and result handshakes.
module cla_seq_adder
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    cla_seq_adder_if.slave  bus
);
    localparam int NIBBLES = nibbles(WIDTH);
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    generate
        if (((WIDTH % NIB_W) != 0) || (WIDTH < NIB_W)) begin : g_bad_width
            $error("cla_seq_adder: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;

    logic [IDX_W+1:0]   base_s;
    logic [NIB_W-1:0]   nib_sum_s;
    logic               nib_cout_s;

    assign base_s = {idx_q, 2'b00};

    cla_4bit u_slice (
        .a    (a_q[base_s +: NIB_W]),
        .b    (b_q[base_s +: NIB_W]),
        .cin  (carry_q),
        .sum  (nib_sum_s),
        .cout (nib_cout_s)
    );

    // Next-state, operand capture and nibble accumulation.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        work_d  = work_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    idx_d   = '0;
                    work_d  = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                work_d[base_s +: NIB_W] = nib_sum_s;
                carry_d = nib_cout_s;
                if (idx_q == IDX_W'(NIBBLES - 1)) begin
                    // Published result is only updated here so it holds across the next accept.
                    idx_d   = '0;
                    sum_d   = work_d;
                    cout_d  = nib_cout_s;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (nib_sum_s[NIB_W-1] != a_q[WIDTH-1]);
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = RUN;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            work_q      <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            work_q      <= work_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed and random checks of cla_seq_adder at WIDTH=16 and WIDTH=4.
module tb_cla_seq_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    cla_seq_adder_if #(.WIDTH(16)) if16 ();
    cla_seq_adder_if #(.WIDTH(4))  if4  ();

    cla_seq_adder #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));
    cla_seq_adder #(.WIDTH(4))  u_dut4  (.clk(clk), .rst(rst), .bus(if4));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One 16-bit addition: accept, wait for result, optional stall, handshake.
    task automatic add16(input logic [15:0] op_a, input logic [15:0] op_b, input logic op_c,
                         input int stall, input bit noise);
        logic [16:0] full;
        logic        exp_ovf;
        int          lat;
        full    = 17'(op_a) + 17'(op_b) + 17'(op_c);
        exp_ovf = (op_a[15] == op_b[15]) && (full[15] != op_a[15]);
        chk("w16_idle_in_ready", 64'(if16.in_ready), 64'(1));
        if16.in_valid = 1'b1;
        if16.a = op_a;
        if16.b = op_b;
        if16.cin = op_c;
        @(negedge clk);
        if16.in_valid = 1'b0;
        if16.a   = 16'($urandom);
        if16.b   = 16'($urandom);
        if16.cin = 1'($urandom_range(0, 1));
        chk("w16_run_in_ready", 64'(if16.in_ready), 64'(0));
        chk("w16_run_busy", 64'(if16.busy), 64'(1));
        lat = 0;
        while (if16.out_valid !== 1'b1 && lat < 20) begin
            if (noise) if16.in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        chk("w16_latency", 64'(lat), 64'(4));
        chk("w16_sum", 64'(if16.sum), 64'(full[15:0]));
        chk("w16_cout", 64'(if16.cout), 64'(full[16]));
        chk("w16_overflow", 64'(if16.overflow), 64'(exp_ovf));
        for (int i = 0; i < stall; i++) begin
            if (noise) if16.in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("w16_stall_sum", 64'(if16.sum), 64'(full[15:0]));
            chk("w16_stall_out_valid", 64'(if16.out_valid), 64'(1));
            chk("w16_stall_in_ready", 64'(if16.in_ready), 64'(0));
        end
        if16.in_valid  = 1'b0;
        if16.out_ready = 1'b1;
        @(negedge clk);
        if16.out_ready = 1'b0;
        chk("w16_post_out_valid", 64'(if16.out_valid), 64'(0));
        chk("w16_post_in_ready", 64'(if16.in_ready), 64'(1));
        chk("w16_post_busy", 64'(if16.busy), 64'(0));
        chk("w16_post_hold_sum", 64'(if16.sum), 64'(full[15:0]));
    endtask

    // One 4-bit addition with immediate handshake.
    task automatic add4(input logic [3:0] op_a, input logic [3:0] op_b, input logic op_c);
        logic [4:0] full;
        logic       exp_ovf;
        int         lat;
        full    = 5'(op_a) + 5'(op_b) + 5'(op_c);
        exp_ovf = (op_a[3] == op_b[3]) && (full[3] != op_a[3]);
        if4.in_valid = 1'b1;
        if4.a = op_a;
        if4.b = op_b;
        if4.cin = op_c;
        @(negedge clk);
        if4.in_valid = 1'b0;
        if4.a = 4'($urandom);
        if4.b = 4'($urandom);
        lat = 0;
        while (if4.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("w4_latency", 64'(lat), 64'(1));
        chk("w4_sum", 64'(if4.sum), 64'(full[3:0]));
        chk("w4_cout", 64'(if4.cout), 64'(full[4]));
        chk("w4_overflow", 64'(if4.overflow), 64'(exp_ovf));
        if4.out_ready = 1'b1;
        @(negedge clk);
        if4.out_ready = 1'b0;
        chk("w4_post_in_ready", 64'(if4.in_ready), 64'(1));
    endtask

    initial begin
        if16.in_valid = 1'b0; if16.a = 16'h0000; if16.b = 16'h0000; if16.cin = 1'b0;
        if16.out_ready = 1'b0;
        if4.in_valid = 1'b0;  if4.a = 4'h0;      if4.b = 4'h0;      if4.cin = 1'b0;
        if4.out_ready = 1'b0;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(if16.in_ready), 64'(1));
        chk("rst_out_valid", 64'(if16.out_valid), 64'(0));
        chk("rst_busy", 64'(if16.busy), 64'(0));
        chk("rst_sum", 64'(if16.sum), 64'(0));
        chk("rst_cout", 64'(if16.cout), 64'(0));
        chk("rst_overflow", 64'(if16.overflow), 64'(0));
        chk("rst4_in_ready", 64'(if4.in_ready), 64'(1));
        rst = 1'b0;

        add16(16'h0001, 16'h0001, 1'b0, 0, 1'b0);
        add16(16'hFFFF, 16'h0000, 1'b1, 0, 1'b0);
        add16(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
        add16(16'h8000, 16'h8000, 1'b0, 0, 1'b0);
        add16(16'h1234, 16'h4321, 1'b0, 10, 1'b1);

        // Abort after two nibbles have been processed.
        if16.in_valid = 1'b1; if16.a = 16'hAAAA; if16.b = 16'h5555; if16.cin = 1'b0;
        @(negedge clk);
        if16.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", 64'(if16.in_ready), 64'(1));
        chk("abort_out_valid", 64'(if16.out_valid), 64'(0));
        chk("abort_sum", 64'(if16.sum), 64'(0));
        chk("abort_cout", 64'(if16.cout), 64'(0));
        @(negedge clk);
        chk("abort_no_late_valid", 64'(if16.out_valid), 64'(0));
        add16(16'h0F0F, 16'h00F1, 1'b0, 0, 1'b0);

        for (int k = 0; k < 20; k++) begin
            add16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), 1'b1);
        end

        add4(4'b1111, 4'b1111, 1'b1);
        add4(4'b0111, 4'b0001, 1'b0);
        for (int k = 0; k < 8; k++) begin
            add4(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
